// File: rtl/serial_add_sub_n.sv
// Bit-serial add/subtract unit: one result bit per cycle, LSB first, with an
// unsigned magnitude compare of the operands computed in the same pass.
module serial_add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic [1:0]       fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part;
  logic             s_q;
  logic             c;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    cnt;

  logic ai, bi, bit_r, c_n, gt_n, lt_n, last;

  always_comb begin
    ai    = a_q[cnt];
    bi    = b_q[cnt] ^ s_q;
    bit_r = ai ^ bi ^ c;
    c_n   = (ai & bi) | (ai & c) | (bi & c);
    // Later (more significant) differing bits overwrite earlier ones.
    gt_n  = (a_q[cnt] != b_q[cnt]) ?  a_q[cnt] : gt;
    lt_n  = (a_q[cnt] != b_q[cnt]) ? ~a_q[cnt] : lt;
    last  = (cnt == CW'(WIDTH - 1));
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part     <= '0;
      s_q      <= 1'b0;
      c        <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      less     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            s_q   <= s;
            c     <= s;
            cnt   <= '0;
            part  <= '0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          c    <= c_n;
          part <= {bit_r, part[WIDTH-1:1]};
          gt   <= gt_n;
          lt   <= lt_n;
          cnt  <= cnt + CW'(1);
          if (last) begin
            // Visible results change only here, on entry to DONE.
            sum      <= {bit_r, part[WIDTH-1:1]};
            carry    <= c_n;
            overflow <= c ^ c_n;
            greater  <= gt_n;
            less     <= lt_n;
            equal    <= ~(gt_n | lt_n);
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
